// File: rtl/add8_pkg.sv
// Shared constants and FSM state type for the add8 nibble-plane result reader.
package add8_pkg;
  localparam int ADD8_LANES  = 32;
  localparam int ADD8_NIB_W  = 4;
  localparam int ADD8_BYTE_W = 8;

  localparam logic [ADD8_BYTE_W-1:0] ADD8_CLIP_VAL = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } add8_state_e;
endpackage

// File: rtl/add8_lane_join.sv
// Joins low/high nibble planes into per-lane bytes; with ADD8_UNPACK_CLIP_EN
// also flags lanes holding the datapath clip marker.
module add8_lane_join
  import add8_pkg::*;
(
  input  logic [ADD8_LANES*ADD8_NIB_W-1:0]  dst0,
  input  logic [ADD8_LANES*ADD8_NIB_W-1:0]  dst1,
  output logic [ADD8_LANES*ADD8_BYTE_W-1:0] lane_bytes
`ifdef ADD8_UNPACK_CLIP_EN
  ,
  output logic [ADD8_LANES-1:0]             clip_flag
`endif
);
  for (genvar i = 0; i < ADD8_LANES; i++) begin : g_lane
    assign lane_bytes[i*ADD8_BYTE_W +: ADD8_BYTE_W] =
      {dst1[i*ADD8_NIB_W +: ADD8_NIB_W], dst0[i*ADD8_NIB_W +: ADD8_NIB_W]};
`ifdef ADD8_UNPACK_CLIP_EN
    assign clip_flag[i] = (lane_bytes[i*ADD8_BYTE_W +: ADD8_BYTE_W] == ADD8_CLIP_VAL);
`endif
  end
endmodule

// File: rtl/add8_result_unpack.sv
// Captures a 32-lane nibble-plane result vector and drains it LANES_PER_BEAT
// bytes per beat. Clip reporting ports exist only with ADD8_UNPACK_CLIP_EN.
module add8_result_unpack
  import add8_pkg::*;
#(
  parameter int LANES_PER_BEAT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ADD8_LANES*ADD8_NIB_W-1:0]    dst0,
  input  logic [ADD8_LANES*ADD8_NIB_W-1:0]    dst1,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADD8_BYTE_W*LANES_PER_BEAT-1:0] out_data,
  output logic [4:0]                          out_idx,
  output logic                                out_first,
  output logic                                out_last
`ifdef ADD8_UNPACK_CLIP_EN
  ,
  output logic [LANES_PER_BEAT-1:0]           out_clip,
  output logic [5:0]                          clip_cnt
`endif
);
  localparam int NB = ADD8_LANES / LANES_PER_BEAT;
  localparam int OW = ADD8_BYTE_W * LANES_PER_BEAT;
  localparam int SH = $clog2(LANES_PER_BEAT);
  localparam int BW = ADD8_LANES * ADD8_BYTE_W;
  localparam logic [4:0] LAST_BEAT = 5'(NB - 1);

  if (!(LANES_PER_BEAT == 1 || LANES_PER_BEAT == 2 || LANES_PER_BEAT == 4 ||
        LANES_PER_BEAT == 8 || LANES_PER_BEAT == 16 || LANES_PER_BEAT == 32)) begin : g_bad_lpb
    $error("add8_result_unpack: LANES_PER_BEAT must be 1,2,4,8,16 or 32");
  end

  add8_state_e    state_q, state_d;
  logic [4:0]     beat_q, beat_d;
  logic [BW-1:0]  buf_q;
  logic [BW-1:0]  join_bytes;
  logic [7:0]     bit_off;
  logic           capture, is_last;

`ifdef ADD8_UNPACK_CLIP_EN
  logic [ADD8_LANES-1:0] clip_flag;
  logic [5:0]            clip_sum;
`endif

  add8_lane_join u_join (
    .dst0       (dst0),
    .dst1       (dst1),
    .lane_bytes (join_bytes)
`ifdef ADD8_UNPACK_CLIP_EN
    ,
    .clip_flag  (clip_flag)
`endif
  );

  assign is_last  = (state_q == ST_DRAIN) && (beat_q == LAST_BEAT);
  // Last-beat handoff lets the next vector load in the same edge: no bubble.
  assign in_ready = !rst && ((state_q == ST_IDLE) || (is_last && out_ready));
  assign capture  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (capture) begin
      state_d = ST_DRAIN;
      beat_d  = '0;
    end else if (state_q == ST_DRAIN && out_ready) begin
      if (is_last) begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (capture) buf_q <= join_bytes;
    end
  end

  // Outputs come only from buf_q/beat_q/state_q, so they hold through stalls.
  assign bit_off   = {beat_q, 3'b000} << SH;
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = buf_q[bit_off +: OW];
  assign out_idx   = beat_q << SH;
  assign out_first = out_valid && (beat_q == 5'd0);
  assign out_last  = is_last;

`ifdef ADD8_UNPACK_CLIP_EN
  for (genvar j = 0; j < LANES_PER_BEAT; j++) begin : g_clip
    assign out_clip[j] = (out_data[j*ADD8_BYTE_W +: ADD8_BYTE_W] == ADD8_CLIP_VAL);
  end

  always_comb begin
    clip_sum = '0;
    for (int i = 0; i < ADD8_LANES; i++) clip_sum = clip_sum + 6'(clip_flag[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)          clip_cnt <= '0;
    else if (capture) clip_cnt <= clip_sum;
  end
`endif
endmodule
